// File: rtl/fxp_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper for the
// sign-magnitude fixed-point arithmetic blocks (divider, multiplier).
package fxp_pkg;

  localparam int DEF_WIDTH = 15;
  localparam int DEF_FBITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fxp_state_e;

  // Largest representable magnitude for a given magnitude width.
  function automatic logic [31:0] sat_mag(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/fxp_div.sv
// Sequential sign-magnitude fixed-point divider: restoring division, one
// quotient bit per clock, with saturation and divide-by-zero reporting.
module fxp_div
  import fxp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic             clk_i,
  input  logic             nReset_i,
  input  logic             start_i,
  input  logic [WIDTH:0]   dividend_i,
  input  logic [WIDTH:0]   divisor_i,
  output logic [WIDTH:0]   quot_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o,
  output logic             ovf_o
);

  localparam int N     = WIDTH + FBITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_mag(WIDTH));

  fxp_state_e       r_state;
  logic [N-1:0]     r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_quot;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic             r_ovf;

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  logic [N-1:0]     w_quo_nxt;

  function automatic logic [WIDTH-1:0] sat_quo(input logic [N-1:0] q);
    return (|q[N-1:WIDTH]) ? SAT : q[WIDTH-1:0];
  endfunction

  // A zero magnitude always carries a positive sign.
  function automatic logic [WIDTH:0] pack_res(input logic sign,
                                              input logic [WIDTH-1:0] mag);
    return {sign & (|mag), mag};
  endfunction

  // r_quo starts as the scaled dividend and shifts quotient bits in from the
  // bottom as the dividend bits shift out of the top.
  always_comb begin
    w_trial   = {r_rem, r_quo[N-1]};
    w_qbit    = (w_trial >= (WIDTH+2)'(r_dvs));
    w_diff    = w_trial - (WIDTH+2)'(r_dvs);
    w_quo_nxt = {r_quo[N-2:0], w_qbit};
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_state <= ST_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_sign <= dividend_i[WIDTH] ^ divisor_i[WIDTH];
            r_dvs  <= divisor_i[WIDTH-1:0];
            r_quo  <= {dividend_i[WIDTH-1:0], {FBITS{1'b0}}};
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (divisor_i[WIDTH-1:0] == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
              r_ovf   <= 1'b0;
              r_quot  <= pack_res(dividend_i[WIDTH] ^ divisor_i[WIDTH], SAT);
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_quo <= w_quo_nxt;
          r_rem <= (WIDTH+1)'(w_qbit ? w_diff : w_trial);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_dz    <= 1'b0;
            r_ovf   <= |w_quo_nxt[N-1:WIDTH];
            r_quot  <= pack_res(r_sign, sat_quo(w_quo_nxt));
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign quot_o = r_quot;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign dz_o   = r_dz;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_fxp_div.sv
// Scoreboard bench for fxp_div (WIDTH=15, FBITS=10): directed vectors with
// hand-computed quotients, flags and latencies.
module tb_fxp_div;

  typedef struct {
    string       nm;
    logic [15:0] q;
    logic        dz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        nReset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] dividend_i = '0;
  logic [15:0] divisor_i = '0;
  logic [15:0] quot_o;
  logic        busy_o, done_o, dz_o, ovf_o;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  fxp_div #(.WIDTH(15), .FBITS(10)) dut (
    .clk_i(clk_i), .nReset_i(nReset_i), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .quot_o(quot_o),
    .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses done_o.
  initial forever begin
    @(negedge clk_i);
    if (nReset_i && done_o) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got quot %h with empty scoreboard", quot_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_quot"}, 32'(quot_o), 32'(e.q));
        chk({e.nm, "_dz"}, 32'(dz_o), 32'(e.dz));
        chk({e.nm, "_ovf"}, 32'(ovf_o), 32'(e.ovf));
        chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        chk({e.nm, "_busy"}, 32'(busy_o), 32'd1);
        chk({e.nm, "_single_pulse"}, 32'(prev_done), 32'd0);
      end
    end
    prev_done = done_o;
  end

  task automatic push(input string nm, input logic [15:0] q, input logic dz, input logic ovf);
    exp_t e;
    e.nm = nm; e.q = q; e.dz = dz; e.ovf = ovf;
    e.lat = dz ? 1 : 26;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      #1;
      if (n_done >= target) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL %s_timeout: got %0d results, expected %0d", nm, n_done, target);
  endtask

  task automatic run_vec(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic dz, input logic ovf);
    int nd0;
    nd0 = n_done;
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    @(posedge clk_i);
    #1;
    push(nm, q, dz, ovf);
    start_i = 1'b0; dividend_i = 16'hFFFF; divisor_i = 16'h7FFF;
    wait_done(nd0 + 1, nm);
  endtask

  initial begin
    int nd0;
    #12;
    chk("rst_quot", 32'(quot_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_dz",   32'(dz_o),   32'h0);
    chk("rst_ovf",  32'(ovf_o),  32'h0);
    @(negedge clk_i);
    nReset_i = 1'b1;

    run_vec("v3_div_2",     16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0);
    run_vec("vm1_div_half", 16'h8400, 16'h0200, 16'h8800, 1'b0, 1'b0);
    run_vec("vnegzero",     16'h8000, 16'h8400, 16'h0000, 1'b0, 1'b0);
    run_vec("vzero_neg",    16'h0000, 16'h8400, 16'h0000, 1'b0, 1'b0);
    run_vec("vdz_pos",      16'h1400, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
    run_vec("vdz_neg",      16'h0400, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    run_vec("vovf16",       16'h4000, 16'h0100, 16'h7FFF, 1'b0, 1'b1);
    run_vec("vlsb",         16'h0001, 16'h0400, 16'h0001, 1'b0, 1'b0);
    run_vec("vthird",       16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0);
    run_vec("vneg_third",   16'h8400, 16'h0C00, 16'h8155, 1'b0, 1'b0);
    run_vec("vmax_max",     16'h7FFF, 16'h7FFF, 16'h0400, 1'b0, 1'b0);
    run_vec("vmax_one",     16'h7FFF, 16'h0400, 16'h7FFF, 1'b0, 1'b0);
    run_vec("vtrunc_zero",  16'h8001, 16'h7FFF, 16'h0000, 1'b0, 1'b0);

    // Start pulsed mid-CALC with other operands must be ignored.
    nd0 = n_done;
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 16'h0C00; divisor_i = 16'h0800;
    @(posedge clk_i);
    #1;
    push("vmid_start", 16'h0600, 1'b0, 1'b0);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    start_i = 1'b1; dividend_i = 16'h0400; divisor_i = 16'h0400;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(nd0 + 1, "vmid_start");
    repeat (30) @(negedge clk_i);

    // Start held high: back-to-back divisions.
    nd0 = n_done;
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 16'h0C00; divisor_i = 16'h0800;
    @(posedge clk_i);
    #1;
    push("vb2b_a", 16'h0600, 1'b0, 1'b0);
    dividend_i = 16'h8400; divisor_i = 16'h0200;
    wait_done(nd0 + 1, "vb2b_a");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    push("vb2b_b", 16'h8800, 1'b0, 1'b0);
    start_i = 1'b0;
    wait_done(nd0 + 2, "vb2b_b");

    // Leave ovf_o and a non-zero quot_o set, then reset mid-CALC.
    run_vec("vovf8", 16'h2000, 16'h0100, 16'h7FFF, 1'b0, 1'b1);
    @(negedge clk_i);
    start_i = 1'b1; dividend_i = 16'h0C00; divisor_i = 16'h0800;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3;
    nReset_i = 1'b0;
    #1;
    chk("arst_quot", 32'(quot_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    chk("arst_dz",   32'(dz_o),   32'h0);
    chk("arst_ovf",  32'(ovf_o),  32'h0);
    start_i = 1'b1;
    @(negedge clk_i);
    chk("arst_no_accept", 32'(busy_o), 32'h0);
    start_i = 1'b0;
    nReset_i = 1'b1;
    run_vec("vpost_rst", 16'h0400, 16'h0200, 16'h0800, 1'b0, 1'b0);

    repeat (30) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
